// File: rtl/mem_if_pkg.sv
// Shared types and constants for the command-processor memory responder.
// FSM state encoding, access-mode codes and the default storage depth.
package mem_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESPOND,
    S_RELEASE
  } mem_state_t;

  localparam logic MMODE_READ  = 1'b0;
  localparam logic MMODE_WRITE = 1'b1;

  localparam int unsigned MEM_DEPTH_DEFAULT = 256 * 256;
  localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/memory_responder_mem_array.sv
// Single-port synchronous word RAM with a registered, reset-able read port.
// Storage itself is never reset; its power-up content is the program image.
module mem_array #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Latency-configurable memory responder for the command processor.
// Optional write protection below PROT_LIMIT: MEM_WRITE_PROTECT_EN.
module memory_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = $clog2(MEM_DEPTH_DEFAULT),
  parameter int LATENCY     = 2,
  parameter int RESP_CYCLES = 1
`ifdef MEM_WRITE_PROTECT_EN
  , parameter logic [15:0] PROT_LIMIT = 16'h0100
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_block,
  input  logic        mem_mode,
  input  logic [15:0] mem_locator,
  input  logic [15:0] mem_write,
  output logic [15:0] mem_read,
  output logic        mem_response,
  output logic        busy
`ifdef MEM_WRITE_PROTECT_EN
  , output logic      prot_fault
`endif
);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mode_q, mode_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              resp_q, resp_d;
  logic              commit;
  logic              wr_ok;
  logic              ram_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mode_q  <= MMODE_READ;
      wdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

  // Request fields are captured once in IDLE and frozen until the next accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_block) begin
          addr_d  = mem_locator[ADDR_W-1:0];
          mode_d  = mem_mode;
          wdata_d = mem_write;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = CNT_W'(RESP_CYCLES - 1);
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!mem_block) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MEM_WRITE_PROTECT_EN
  logic fault_q, fault_d;

  assign wr_ok = 32'(addr_q) >= 32'(PROT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  always_comb begin
    fault_d = fault_q;
    if (commit && mode_q == MMODE_WRITE && !wr_ok) fault_d = 1'b1;
  end

  assign prot_fault = fault_q;
`else
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    commit = (state_q == S_ACCESS) && (cnt_q == '0);
    ram_we = (mode_q == MMODE_WRITE) && wr_ok;
    resp_d = resp_q;
    if (commit) resp_d = 1'b1;
    else if (state_q == S_RESPOND && cnt_q == '0) resp_d = 1'b0;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_read)
  );

  assign mem_response = resp_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed plus randomized bench for memory_responder.
// Expected data comes from an associative-array memory model.
module tb_memory_responder;

  localparam int L = 2;
  localparam int R = 1;
  localparam logic [15:0] LIMIT = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_block;
  logic        mem_mode;
  logic [15:0] mem_locator;
  logic [15:0] mem_write;
  logic [15:0] mem_read;
  logic        mem_response;
  logic        busy;
`ifdef MEM_WRITE_PROTECT_EN
  logic        prot_fault;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [logic [15:0]];
  logic [15:0] exp_rd;
  bit          exp_valid;
  bit          exp_fault;

  memory_responder #(
    .ADDR_W      (16),
    .LATENCY     (L),
    .RESP_CYCLES (R)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_block    (mem_block),
    .mem_mode     (mem_mode),
    .mem_locator  (mem_locator),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_response (mem_response),
    .busy         (busy)
`ifdef MEM_WRITE_PROTECT_EN
    , .prot_fault (prot_fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fault();
`ifdef MEM_WRITE_PROTECT_EN
    chk("prot_fault", {15'b0, prot_fault}, {15'b0, exp_fault});
`endif
  endtask

  // Reference behaviour of a completed access.
  task automatic model_commit(input logic mode, input logic [15:0] addr,
                              input logic [15:0] wd);
    bit allowed = 1'b1;
`ifdef MEM_WRITE_PROTECT_EN
    allowed = (addr >= LIMIT);
`endif
    if (mode) begin
      if (allowed) mdl[addr] = wd;
      else         exp_fault = 1'b1;
    end else if (mdl.exists(addr)) begin
      exp_rd    = mdl[addr];
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic req(input logic mode, input logic [15:0] addr,
                     input logic [15:0] wd, input bit stale,
                     input bit scramble);
    mem_block   = 1'b1;
    mem_mode    = mode;
    mem_locator = addr;
    mem_write   = wd;
    @(posedge clk); #1;
    chk("busy_accept", {15'b0, busy}, 16'd1);
    chk("resp_accept", {15'b0, mem_response}, 16'd0);
    if (scramble) begin
      mem_locator = addr ^ 16'h0030;
      mem_mode    = ~mode;
      mem_write   = ~wd;
    end
    for (int k = 1; k <= L + R; k++) begin
      @(posedge clk); #1;
      if (k == L) model_commit(mode, addr, wd);
      chk($sformatf("resp_k%0d", k), {15'b0, mem_response},
          {15'b0, (k >= L && k < L + R)});
      chk($sformatf("busy_k%0d", k), {15'b0, busy}, 16'd1);
      if (exp_valid) chk($sformatf("rd_k%0d", k), mem_read, exp_rd);
    end
    if (stale) begin
      for (int s = 0; s < 3; s++) begin
        @(posedge clk); #1;
        chk("stale_busy", {15'b0, busy}, 16'd1);
        chk("stale_resp", {15'b0, mem_response}, 16'd0);
        if (exp_valid) chk("stale_rd", mem_read, exp_rd);
      end
    end
    mem_block = 1'b0;
    @(posedge clk); #1;
    chk("busy_idle", {15'b0, busy}, 16'd0);
    chk_fault();
  endtask

  task automatic reset_mid_write(input logic [15:0] addr,
                                 input logic [15:0] wd);
    mem_block   = 1'b1;
    mem_mode    = 1'b1;
    mem_locator = addr;
    mem_write   = wd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_resp", {15'b0, mem_response}, 16'd0);
    chk("rst_mid_busy", {15'b0, busy}, 16'd0);
    chk("rst_mid_rd", mem_read, 16'h0000);
    mem_block = 1'b0;
    exp_rd    = 16'h0000;
    exp_valid = 1'b1;
    exp_fault = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] pool [8];

  initial begin
    pool = '{16'h0010, 16'hFFFE, 16'h0300, 16'h1234,
             16'h8000, 16'h00FF, 16'h0100, 16'h7777};
    rst_n       = 1'b0;
    mem_block   = 1'b0;
    mem_mode    = 1'b0;
    mem_locator = '0;
    mem_write   = '0;
    exp_rd      = 16'h0000;
    exp_valid   = 1'b1;
    exp_fault   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd", mem_read, 16'h0000);
    chk("reset_resp", {15'b0, mem_response}, 16'd0);
    chk("reset_busy", {15'b0, busy}, 16'd0);
    chk_fault();
    @(negedge clk);
    rst_n = 1'b1;

    req(1'b1, 16'h0010, 16'hADD0, 1'b0, 1'b0);
    req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    req(1'b1, 16'hFFFE, 16'h1234, 1'b0, 1'b0);
    req(1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    chk("wr_rd_fffe", mem_read, 16'h1234);
    req(1'b1, 16'h0020, 16'h2020, 1'b0, 1'b0);
    req(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1);
    req(1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0);
    req(1'b1, 16'hFFFE, 16'h4321, 1'b1, 1'b1);
    req(1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0);

    req(1'b1, 16'h0300, 16'h5A5A, 1'b0, 1'b0);
    reset_mid_write(16'h0300, 16'hDEAD);
    chk_fault();
    req(1'b0, 16'h0300, 16'h0000, 1'b0, 1'b0);
    chk("rst_keep_0300", mem_read, 16'h5A5A);

`ifdef MEM_WRITE_PROTECT_EN
    // Learn the image word at 0x0050 so its preservation can be checked.
    req(1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0);
    mdl[16'h0050] = mem_read;
    exp_rd        = mem_read;
    exp_valid     = 1'b1;
`endif
    req(1'b1, 16'h0050, 16'hBEEF, 1'b0, 1'b0);
    req(1'b0, 16'h0050, 16'h0000, 1'b0, 1'b0);
    req(1'b1, LIMIT, 16'h0101, 1'b0, 1'b0);
    req(1'b0, LIMIT, 16'h0000, 1'b0, 1'b0);
    chk("limit_commit", mem_read, 16'h0101);

    for (int i = 0; i < 24; i++) begin
      req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
          16'($urandom), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
